// File: rtl/snake_body_tracker_if.sv
// Signal bundle between the game controller, the apple generator, the VGA painter and the snake body tracker.
interface snake_body_tracker_if;
  logic       game_en;
  logic [3:0] dir_key;
  logic       add_cube;
  logic [5:0] query_x;
  logic [5:0] query_y;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [5:0] length;
  logic       move_tick;
  logic       hit_wall;
  logic       hit_body;
  logic       query_hit;

  modport master (
    output game_en, dir_key, add_cube, query_x, query_y,
    input  head_x, head_y, length, move_tick, hit_wall, hit_body, query_hit
  );

  modport slave (
    input  game_en, dir_key, add_cube, query_x, query_y,
    output head_x, head_y, length, move_tick, hit_wall, hit_body, query_hit
  );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake position/length on the cell grid: steps one cell per move tick in the latched direction,
// grows on request, flags wall/self collisions and answers the painter's combinational cell query.
module snake_body_tracker #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int TICK_DIV = 12_500_000,
  parameter int INIT_X   = 10,
  parameter int INIT_Y   = 10
) (
  input logic                 clk,
  input logic                 rst,
  snake_body_tracker_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t           state;
  logic [3:0]       dir;
  logic [3:0]       last_dir;
  logic [CNT_W-1:0] cnt;
  logic             grow_pending;
  logic             move_tick;
  logic             hit_wall;
  logic             hit_body;
  logic [5:0]       length;
  logic [5:0]       seg_x [MAX_LEN];
  logic [5:0]       seg_y [MAX_LEN];

  logic [3:0] dir_nxt;
  logic [5:0] nh_x;
  logic [5:0] nh_y;
  logic       key_ok;
  logic       grow_eff;
  logic       growing;
  logic       wall;
  logic       body;
  logic       step;
  logic       query_hit;

  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // A request is only rejected when it would reverse onto the neck (the dir of the last step).
  always_comb begin
    key_ok   = $onehot(bus.dir_key) && (bus.dir_key != opposite(last_dir));
    dir_nxt  = key_ok ? bus.dir_key : dir;
    grow_eff = grow_pending | bus.add_cube;
    growing  = grow_eff && (length < 6'(MAX_LEN));
    step     = (state == RUN) && move_tick;
    nh_x     = seg_x[0];
    nh_y     = seg_y[0];
    if (dir_nxt[3])      nh_y = seg_y[0] - 6'd1;
    else if (dir_nxt[2]) nh_y = seg_y[0] + 6'd1;
    else if (dir_nxt[1]) nh_x = seg_x[0] - 6'd1;
    else                 nh_x = seg_x[0] + 6'd1;
    wall = (nh_x == 6'd0) || (nh_x == 6'(GRID_W - 1)) ||
           (nh_y == 6'd0) || (nh_y == 6'(GRID_H - 1));
    body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      // The tail cell vacates this step unless the snake grows, so moving onto it is legal.
      if ((6'(i) < length) && !(!growing && (6'(i) == length - 6'd1)) &&
          (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
        body = 1'b1;
    end
  end

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < length) && (seg_x[i] == bus.query_x) && (seg_y[i] == bus.query_y))
        query_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      dir          <= DIR_RIGHT;
      last_dir     <= DIR_RIGHT;
      cnt          <= '0;
      grow_pending <= 1'b0;
      move_tick    <= 1'b0;
      hit_wall     <= 1'b0;
      hit_body     <= 1'b0;
      length       <= 6'(INIT_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? 6'(INIT_X - i) : 6'd0;
        seg_y[i] <= (i < INIT_LEN) ? 6'(INIT_Y) : 6'd0;
      end
    end else begin
      move_tick    <= 1'b0;
      grow_pending <= grow_eff;
      case (state)
        IDLE: begin
          dir <= dir_nxt;
          if (bus.game_en) state <= RUN;
        end
        RUN: begin
          dir <= dir_nxt;
          if (!bus.game_en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            move_tick <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          // Step cycle: collision takes priority over a concurrent game_en drop.
          if (step) begin
            if (wall) begin
              state    <= DEAD;
              hit_wall <= 1'b1;
            end else if (body) begin
              state    <= DEAD;
              hit_body <= 1'b1;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0]     <= nh_x;
              seg_y[0]     <= nh_y;
              last_dir     <= dir_nxt;
              grow_pending <= 1'b0;
              if (growing) length <= length + 6'd1;
            end
          end
        end
        default: begin
          state <= DEAD;
        end
      endcase
    end
  end

  assign bus.head_x    = seg_x[0];
  assign bus.head_y    = seg_y[0];
  assign bus.length    = length;
  assign bus.move_tick = move_tick;
  assign bus.hit_wall  = hit_wall;
  assign bus.hit_body  = hit_body;
  assign bus.query_hit = query_hit;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker: stepping, turning, growth, wall/body death and reset.
module tb_snake_body_tracker;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  snake_body_tracker_if bus();

  snake_body_tracker #(
    .MAX_LEN(16), .INIT_LEN(3), .GRID_W(40), .GRID_H(30),
    .TICK_DIV(4), .INIT_X(10), .INIT_Y(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge just after the step edge; nw = negedges waited for move_tick.
  task automatic step_wait(output int nw);
    nw = 0;
    while (bus.move_tick !== 1'b1 && nw < 40) begin
      @(negedge clk);
      nw++;
    end
    chk("tick_seen", int'(bus.move_tick), 1);
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] k);
    bus.dir_key = k;
    @(negedge clk);
    bus.dir_key = 4'b0000;
  endtask

  task automatic pulse_add();
    bus.add_cube = 1'b1;
    @(negedge clk);
    bus.add_cube = 1'b0;
  endtask

  task automatic chk_q(input string tag, input int x, input int y, input int exp);
    bus.query_x = 6'(x);
    bus.query_y = 6'(y);
    #1;
    chk(tag, int'(bus.query_hit), exp);
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(bus.head_x), x);
    chk({tag, "_y"}, int'(bus.head_y), y);
  endtask

  initial begin
    rst = 1'b0;
    bus.game_en = 1'b0;
    bus.dir_key = 4'b0000;
    bus.add_cube = 1'b0;
    bus.query_x = 6'd0;
    bus.query_y = 6'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk_head("rst_head", 10, 10);
    chk("rst_len", int'(bus.length), 3);
    chk("rst_tick", int'(bus.move_tick), 0);
    chk("rst_wall", int'(bus.hit_wall), 0);
    chk("rst_body", int'(bus.hit_body), 0);
    chk_q("rst_q_tail", 8, 10, 1);
    chk_q("rst_q_out", 7, 10, 0);

    // T1: free run to the right every 4 clocks
    rst = 1'b1;
    bus.game_en = 1'b1;
    step_wait(n);
    chk_head("t1_step1", 11, 10);
    step_wait(n);
    chk("t1_period", n, 3);
    chk_head("t1_step2", 12, 10);
    chk("t1_len", int'(bus.length), 3);
    chk_q("t1_q_tail", 10, 10, 1);
    chk_q("t1_q_vacated", 9, 10, 0);

    // T2: reverse request ignored, up accepted
    key(4'b0010);
    step_wait(n);
    chk_head("t2_left_ign", 13, 10);
    key(4'b1000);
    step_wait(n);
    chk_head("t2_up", 13, 9);

    // T3: three add_cube cycles grow by one; tail stays put on that step
    bus.add_cube = 1'b1;
    repeat (3) @(negedge clk);
    bus.add_cube = 1'b0;
    step_wait(n);
    chk_head("t3_grow", 13, 8);
    chk("t3_len4", int'(bus.length), 4);
    chk_q("t3_tail_kept", 12, 10, 1);
    step_wait(n);
    chk("t3_len_hold", int'(bus.length), 4);
    chk_q("t3_tail_moved", 12, 10, 0);

    // Chase own tail at length 4: legal
    key(4'b0001);
    step_wait(n);
    chk_head("chase_r", 14, 7);
    key(4'b0100);
    step_wait(n);
    chk_head("chase_d", 14, 8);
    key(4'b0010);
    step_wait(n);
    chk_head("chase_l", 13, 8);
    chk("chase_body", int'(bus.hit_body), 0);

    // T5: grow to 5 and turn into own body
    pulse_add();
    step_wait(n);
    chk_head("t5_grow", 12, 8);
    chk("t5_len5", int'(bus.length), 5);
    key(4'b1000);
    step_wait(n);
    chk_head("t5_up", 12, 7);
    key(4'b0001);
    step_wait(n);
    chk_head("t5_right", 13, 7);
    key(4'b0100);
    step_wait(n);
    chk("t5_hit_body", int'(bus.hit_body), 1);
    chk("t5_hit_wall", int'(bus.hit_wall), 0);
    chk_head("t5_no_move", 13, 7);
    chk("t5_len", int'(bus.length), 5);
    chk_q("t5_q_dead", 14, 8, 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      bus.game_en = (i == 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.move_tick === 1'b1) n++;
    end
    chk("t5_no_ticks", n, 0);
    chk("t5_body_sticky", int'(bus.hit_body), 1);
    chk_head("t5_dead_hold", 13, 7);

    // Reset out of DEAD, then T4: run right into the wall
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_head("rst2_head", 10, 10);
    chk("rst2_body", int'(bus.hit_body), 0);
    for (int i = 0; i < 28; i++) step_wait(n);
    chk_head("t4_edge", 38, 10);
    step_wait(n);
    chk("t4_hit_wall", int'(bus.hit_wall), 1);
    chk("t4_hit_body", int'(bus.hit_body), 0);
    chk_head("t4_no_move", 38, 10);
    chk_q("t4_q_dead", 36, 10, 1);

    // T6: reset mid-run with grow pending
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step_wait(n);
    chk_head("t6_run", 11, 10);
    pulse_add();
    rst = 1'b0;
    bus.game_en = 1'b0;
    @(negedge clk);
    chk_head("t6_rst_head", 10, 10);
    chk("t6_rst_len", int'(bus.length), 3);
    chk("t6_rst_tick", int'(bus.move_tick), 0);
    chk("t6_rst_wall", int'(bus.hit_wall), 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk_head("t6_idle_hold", 10, 10);
    bus.game_en = 1'b1;
    step_wait(n);
    chk_head("t6_restart", 11, 10);
    chk("t6_no_grow", int'(bus.length), 3);
    chk_q("t6_q_old_tail", 8, 10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
